// File: rtl/bin2roman_pkg.sv
// Shared symbol codes, greedy conversion table and FSM states for the
// streaming binary-to-Roman encoder.
package bin2roman_pkg;

    typedef enum logic [2:0] {
        SYM_NULL = 3'd0,
        SYM_I    = 3'd1,
        SYM_V    = 3'd2,
        SYM_X    = 3'd3,
        SYM_L    = 3'd4,
        SYM_C    = 3'd5,
        SYM_D    = 3'd6,
        SYM_M    = 3'd7
    } sym_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int TBL_ENTRIES = 13;
    localparam int ROMAN_MAX   = 3999;

    typedef struct packed {
        logic [11:0] value;
        sym_t        sym0;
        sym_t        sym1;
        logic        two_sym;
    } tbl_entry_t;

    // Ordered largest first; two-symbol rows are the subtractive forms.
    function automatic tbl_entry_t tbl_entry(input int idx);
        case (idx)
            0:       tbl_entry = '{12'd1000, SYM_M, SYM_NULL, 1'b0};
            1:       tbl_entry = '{12'd900,  SYM_C, SYM_M,    1'b1};
            2:       tbl_entry = '{12'd500,  SYM_D, SYM_NULL, 1'b0};
            3:       tbl_entry = '{12'd400,  SYM_C, SYM_D,    1'b1};
            4:       tbl_entry = '{12'd100,  SYM_C, SYM_NULL, 1'b0};
            5:       tbl_entry = '{12'd90,   SYM_X, SYM_C,    1'b1};
            6:       tbl_entry = '{12'd50,   SYM_L, SYM_NULL, 1'b0};
            7:       tbl_entry = '{12'd40,   SYM_X, SYM_L,    1'b1};
            8:       tbl_entry = '{12'd10,   SYM_X, SYM_NULL, 1'b0};
            9:       tbl_entry = '{12'd9,    SYM_I, SYM_X,    1'b1};
            10:      tbl_entry = '{12'd5,    SYM_V, SYM_NULL, 1'b0};
            11:      tbl_entry = '{12'd4,    SYM_I, SYM_V,    1'b1};
            12:      tbl_entry = '{12'd1,    SYM_I, SYM_NULL, 1'b0};
            default: tbl_entry = '{12'd0,    SYM_NULL, SYM_NULL, 1'b0};
        endcase
    endfunction

endpackage

// File: rtl/bin2roman_stream_sym_sel.sv
// Combinational greedy selector: picks the largest table entry not exceeding
// the remainder. rem==0 yields value 0 and a NULL symbol.
module roman_sym_sel
    import bin2roman_pkg::*;
#(
    parameter int BIT_WIDTH   = 12,
    parameter int SUBTRACTIVE = 1
) (
    input  logic [BIT_WIDTH-1:0] rem,
    output logic [BIT_WIDTH-1:0] value,
    output sym_t                 sym0,
    output sym_t                 sym1,
    output logic                 two_sym
);

    tbl_entry_t e;

    // Scan smallest to largest so the last hit is the largest fitting entry.
    always_comb begin
        value   = '0;
        sym0    = SYM_NULL;
        sym1    = SYM_NULL;
        two_sym = 1'b0;
        e       = '0;
        for (int i = TBL_ENTRIES - 1; i >= 0; i--) begin
            e = tbl_entry(i);
            if (((SUBTRACTIVE != 0) || !e.two_sym) && (32'(rem) >= 32'(e.value))) begin
                value   = BIT_WIDTH'(e.value);
                sym0    = e.sym0;
                sym1    = e.sym1;
                two_sym = e.two_sym;
            end
        end
    end

endmodule

// File: rtl/bin2roman_stream.sv
// Streaming binary-to-Roman encoder: one value in per handshake, one symbol
// out per cycle, final symbol tagged with sym_last (and sym_err on overflow).
module bin2roman_stream
    import bin2roman_pkg::*;
#(
    parameter int BIT_WIDTH   = 12,
    parameter int MAX_VAL     = 3999,
    parameter int SYM_WIDTH   = 3,
    parameter int SUBTRACTIVE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_data,
    output logic                 sym_valid,
    input  logic                 sym_ready,
    output logic [SYM_WIDTH-1:0] sym,
    output logic                 sym_last,
    output logic                 sym_err
);

    if ((MAX_VAL > ROMAN_MAX) || ((64'd1 << BIT_WIDTH) <= 64'(MAX_VAL)) || (SYM_WIDTH != 3))
    begin : g_bad_params
        $error("bin2roman_stream: MAX_VAL must be <= 3999 and fit BIT_WIDTH; SYM_WIDTH must be 3");
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high. Once raised, sym_valid and its payload stay put until taken;
    // in_ready depends only on registered state, never on in_valid.

    state_t               state_q, state_d;
    logic [BIT_WIDTH-1:0] rem_q, rem_d;
    logic                 pend_valid_q, pend_valid_d;
    sym_t                 pend_sym_q, pend_sym_d;
    logic                 valid_q, valid_d;
    sym_t                 sym_q, sym_d;
    logic                 last_q, last_d;
    logic                 err_q, err_d;

    logic [BIT_WIDTH-1:0] sel_rem, sel_value, greedy_rem;
    sym_t                 sel_sym0, sel_sym1;
    logic                 sel_two, slot_free, load_greedy;

    // In IDLE the selector looks at the incoming value so the first symbol
    // is ready the cycle after accept.
    assign sel_rem = (state_q == ST_IDLE) ? in_data : rem_q;

    roman_sym_sel #(
        .BIT_WIDTH  (BIT_WIDTH),
        .SUBTRACTIVE(SUBTRACTIVE)
    ) u_sel (
        .rem    (sel_rem),
        .value  (sel_value),
        .sym0   (sel_sym0),
        .sym1   (sel_sym1),
        .two_sym(sel_two)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rem_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_sym_q   <= SYM_NULL;
            valid_q      <= 1'b0;
            sym_q        <= SYM_NULL;
            last_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            pend_valid_q <= pend_valid_d;
            pend_sym_q   <= pend_sym_d;
            valid_q      <= valid_d;
            sym_q        <= sym_d;
            last_q       <= last_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        pend_valid_d = pend_valid_q;
        pend_sym_d   = pend_sym_q;
        valid_d      = valid_q;
        sym_d        = sym_q;
        last_d       = last_q;
        err_d        = err_q;
        slot_free    = !valid_q || sym_ready;
        greedy_rem   = sel_rem - sel_value;
        load_greedy  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if ((in_data == '0) || (in_data > BIT_WIDTH'(MAX_VAL))) begin
                        sym_d        = SYM_NULL;
                        valid_d      = 1'b1;
                        last_d       = 1'b1;
                        err_d        = (in_data != '0);
                        rem_d        = '0;
                        pend_valid_d = 1'b0;
                        state_d      = ST_DRAIN;
                    end else begin
                        load_greedy = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (slot_free) begin
                    if (pend_valid_q) begin
                        sym_d        = pend_sym_q;
                        valid_d      = 1'b1;
                        last_d       = (rem_q == '0);
                        err_d        = 1'b0;
                        pend_valid_d = 1'b0;
                        if (rem_q == '0) state_d = ST_DRAIN;
                    end else begin
                        load_greedy = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (sym_ready) begin
                    valid_d = 1'b0;
                    sym_d   = SYM_NULL;
                    last_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_greedy) begin
            sym_d        = sel_sym0;
            pend_sym_d   = sel_sym1;
            pend_valid_d = sel_two;
            rem_d        = greedy_rem;
            valid_d      = 1'b1;
            err_d        = 1'b0;
            last_d       = (greedy_rem == '0) && !sel_two;
            state_d      = last_d ? ST_DRAIN : ST_RUN;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign sym_valid = valid_q;
    assign sym       = SYM_WIDTH'(sym_q);
    assign sym_last  = last_q;
    assign sym_err   = err_q;

endmodule

// File: tb/tb_bin2roman_stream.sv
// Bench for bin2roman_stream: digit-wise Roman reference model feeding an
// expected-symbol queue, checked against the selected DUT's output stream.
module tb_bin2roman_stream;

    localparam int BW = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic [BW-1:0] in_data = '0;
    logic sym_ready = 1'b0;
    logic use_add = 1'b0;

    logic in_valid_s, in_valid_a;
    logic in_ready_s, in_ready_a, sym_valid_s, sym_valid_a;
    logic last_s, last_a, err_s, err_a;
    logic [2:0] sym_s, sym_a;
    logic mon_in_ready, mon_valid, mon_last, mon_err;
    logic [2:0] mon_sym;

    logic [4:0] exp_q[$];
    int unsigned hs_q[$];
    int checks = 0;
    int passes = 0;
    int unsigned cyc = 0;
    int unsigned acc_cyc = 0;
    logic prev_stall = 1'b0;
    logic [4:0] prev_out = '0;

    assign in_valid_s = in_valid && !use_add;
    assign in_valid_a = in_valid && use_add;
    assign mon_in_ready = use_add ? in_ready_a : in_ready_s;
    assign mon_valid = use_add ? sym_valid_a : sym_valid_s;
    assign mon_sym = use_add ? sym_a : sym_s;
    assign mon_last = use_add ? last_a : last_s;
    assign mon_err = use_add ? err_a : err_s;

    bin2roman_stream #(.BIT_WIDTH(BW), .MAX_VAL(3999), .SYM_WIDTH(3), .SUBTRACTIVE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_s), .in_data(in_data),
        .sym_valid(sym_valid_s), .sym_ready(sym_ready), .sym(sym_s), .sym_last(last_s), .sym_err(err_s)
    );

    bin2roman_stream #(.BIT_WIDTH(BW), .MAX_VAL(3999), .SYM_WIDTH(3), .SUBTRACTIVE(0)) dut_add (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data),
        .sym_valid(sym_valid_a), .sym_ready(sym_ready), .sym(sym_a), .sym_last(last_a), .sym_err(err_a)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard monitor: samples on the falling edge, pops on each handshake
    always @(negedge clk) begin
        logic [4:0] got;
        logic [4:0] exp;
        got = {mon_last, mon_err, mon_sym};
        if (rst_n) begin
            if (prev_stall) begin
                checks++;
                if (mon_valid !== 1'b1 || got !== prev_out)
                    $display("FAIL stall_hold: got valid=%b out=%b, required valid=1 out=%b", mon_valid, got, prev_out);
                else
                    passes++;
            end
            if (mon_valid === 1'b1 && sym_ready === 1'b1) begin
                hs_q.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_symbol: got last/err/sym=%b, none expected", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp)
                        $display("FAIL symbol: got last/err/sym=%b, required %b", got, exp);
                    else
                        passes++;
                end
            end
            prev_stall = (mon_valid === 1'b1) && (sym_ready !== 1'b1);
            prev_out = got;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // reference: builds the numeral place by place
    task automatic push_numeral(input int v, input bit sub);
        logic [2:0] s[$];
        logic [2:0] one, five, ten;
        int d, dv;
        if (v == 0) begin exp_q.push_back(5'b10_000); return; end
        if (v > 3999) begin exp_q.push_back(5'b11_000); return; end
        dv = 1000;
        for (int p = 3; p >= 0; p--) begin
            d = (v / dv) % 10;
            case (p)
                3: begin one = 3'd7; five = 3'd0; ten = 3'd0; end
                2: begin one = 3'd5; five = 3'd6; ten = 3'd7; end
                1: begin one = 3'd3; five = 3'd4; ten = 3'd5; end
                default: begin one = 3'd1; five = 3'd2; ten = 3'd3; end
            endcase
            if (sub && d == 9) begin
                s.push_back(one); s.push_back(ten);
            end else if (sub && d == 4) begin
                s.push_back(one); s.push_back(five);
            end else begin
                if (d >= 5) begin s.push_back(five); d -= 5; end
                for (int k = 0; k < d; k++) s.push_back(one);
            end
            dv = dv / 10;
        end
        foreach (s[i]) exp_q.push_back({(i == s.size() - 1), 1'b0, s[i]});
    endtask

    // driver: call at posedge+1; returns at posedge+1 right after the accept edge
    task automatic send(input int v, input bit sub);
        int budget;
        push_numeral(v, sub);
        in_valid = 1'b1;
        in_data = BW'(v);
        budget = 0;
        @(negedge clk);
        while (mon_in_ready !== 1'b1 && budget < 200) begin @(negedge clk); budget++; end
        if (mon_in_ready !== 1'b1) begin
            checks++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", mon_in_ready, budget);
        end
        acc_cyc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int budget = 0;
        while (exp_q.size() != 0 && budget < 500) begin @(posedge clk); #1; budget++; end
        checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL %s_drain: %0d symbols missing, required 0", name, exp_q.size());
            exp_q.delete();
        end else begin
            passes++;
        end
        @(posedge clk); #1;
    endtask

    task automatic drain_random();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 500) begin
            sym_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            budget++;
        end
        sym_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        sym_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sym_valid_s, sym_s, last_s, err_s, sym_valid_a, sym_a, last_a, err_a} !== 12'b0)
            $display("FAIL reset_outputs: got %b/%b, required 0", {sym_valid_s, sym_s, last_s, err_s},
                     {sym_valid_a, sym_a, last_a, err_a});
        else passes++;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready_s !== 1'b1 || in_ready_a !== 1'b1 || sym_valid_s !== 1'b0)
            $display("FAIL reset_ready: got in_ready=%b/%b valid=%b, required 1/1/0", in_ready_s, in_ready_a, sym_valid_s);
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_1994();
        bit bad = 0;
        sym_ready = 1'b1;
        hs_q.delete();
        send(1994, 1'b1);
        wait_drain("1994");
        foreach (hs_q[i]) if (hs_q[i] != acc_cyc + 1 + i) bad = 1;
        checks++;
        if (hs_q.size() != 7 || bad)
            $display("FAIL 1994_timing: got %0d symbols first at cycle %0d, required 7 from %0d",
                     hs_q.size(), (hs_q.size() > 0) ? hs_q[0] : 0, acc_cyc + 1);
        else passes++;
    endtask

    task automatic test_3888();
        int low_bad = 0;
        sym_ready = 1'b1;
        hs_q.delete();
        send(3888, 1'b1);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (mon_in_ready !== 1'b0) low_bad++;
        end
        checks++;
        if (low_bad != 0) $display("FAIL 3888_busy: in_ready high on %0d cycles, required 0", low_bad);
        else passes++;
        @(negedge clk);
        checks++;
        if (mon_in_ready !== 1'b1) $display("FAIL 3888_ready_after: got %b, required 1", mon_in_ready);
        else passes++;
        @(posedge clk); #1;
        wait_drain("3888");
        checks++;
        if (hs_q.size() != 15) $display("FAIL 3888_len: got %0d, required 15", hs_q.size());
        else passes++;
    endtask

    task automatic test_back_to_back();
        int unsigned first_acc;
        sym_ready = 1'b1;
        send(0, 1'b1);
        first_acc = acc_cyc;
        send(4000, 1'b1);
        checks++;
        if (acc_cyc != first_acc + 2)
            $display("FAIL b2b_accept: got cycle %0d, required %0d", acc_cyc, first_acc + 2);
        else passes++;
        send(3999, 1'b1);
        wait_drain("b2b");
    endtask

    task automatic test_stall_49();
        sym_ready = 1'b0;
        send(49, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        drain_random();
        wait_drain("stall49");
    endtask

    task automatic test_additive();
        use_add = 1'b1;
        sym_ready = 1'b1;
        send(4, 1'b0);
        send(9, 1'b0);
        send(40, 1'b0);
        send(3999, 1'b0);
        wait_drain("additive");
        use_add = 1'b0;
    endtask

    task automatic test_async_reset();
        int budget = 0;
        sym_ready = 1'b1;
        hs_q.delete();
        send(3888, 1'b1);
        while (hs_q.size() < 5 && budget < 100) begin @(posedge clk); #1; budget++; end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (sym_valid_s !== 1'b0) $display("FAIL async_reset_valid: got %b, required 0", sym_valid_s);
        else passes++;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready_s !== 1'b1 || sym_valid_s !== 1'b0)
            $display("FAIL post_reset: got in_ready=%b valid=%b, required 1/0", in_ready_s, sym_valid_s);
        else passes++;
        @(posedge clk); #1;
        send(14, 1'b1);
        wait_drain("after_reset_14");
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            bit done;
            int v;
            done = 0;
            v = int'($urandom_range(1, 3999));
            fork
                begin send(v, 1'b1); done = 1; end
                begin
                    while (!done) begin sym_ready = 1'($urandom_range(0, 1)); @(posedge clk); #1; end
                end
            join
            drain_random();
            wait_drain("random");
        end
    endtask

    initial begin
        test_reset();
        test_1994();
        test_3888();
        test_back_to_back();
        test_stall_49();
        test_additive();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
